mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Serves as the responder to the `MDU_op` / `md` / `mt` / `mf` requests issued by the instruction decoder.
- Holds the architectural HI/LO registers and executes mult/multu/div/divu with fixed multi-cycle latency.
- Exposes `busy`/`start` so the hazard unit can stall any D-stage md/mf/mt instruction while an operation is in flight.

Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (and madd when enabled); legal range 1..15.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range 1..15.

Ports:
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `mdu_op`  input  3  E-stage request: 0 idle, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved/madd.
- `kill`  input  1  E-stage instruction is flushed (exception/eret in M); suppresses this cycle's request.
- `rs_val`  input  32  forwarded rs operand.
- `rt_val`  input  32  forwarded rt operand.
- `rd_sel`  input  1  read select for mfhi/mflo: 0 selects HI, 1 selects LO.
- `start`  output  1  combinational; 1 when `mdu_op` is in {1,2,3,4} (or 7 with the feature enabled) and `kill`=0 and `busy`=0.
- `busy`  output  1  registered; operation in flight.
- `hi`  output  32  registered HI value.
- `lo`  output  32  registered LO value.
- `rd_data`  output  32  combinational: `rd_sel` ? `lo` : `hi`.

Behaviour:
- **Reset** (sync, active-high): `hi`=0, `lo`=0, `busy`=0, internal counter=0, latched operands=0.
- Reset asserted mid-operation aborts the operation: no HI/LO writeback, `busy`=0 on the next cycle.
- **Issue:** on an edge where `start`=1:
  - latch `rs_val`, `rt_val` and the op;
  - load counter with `MULT_CYCLES` or `DIV_CYCLES`;
  - set `busy`=1.
- **Count:** while `busy`=1, each edge decrements the counter.
  - On the edge where counter==1, write HI/LO from the latched operands, clear `busy`, clear counter.
- **Timing:** issue at edge N gives `busy`=1 during the `LAT` cycles after edge N. New `hi`/`lo` are visible from edge N+`LAT`.
- **Requests while busy:** any `mdu_op`≠0 while `busy`=1 is ignored (no effect on state). The hazard unit guarantees stall; the MDU does not queue.
- **mthi/mtlo** (5/6) with `kill`=0 and `busy`=0: write `rs_val` to HI/LO at the same edge, single cycle. `busy` and `start` are unaffected.
- **kill=1:** the request that cycle has no effect at all. An operation already in flight is not affected by `kill`.
- **Arithmetic:**
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- **Divide corner cases:**
  - Divide by zero (`rt_val`==0): `busy` asserts for the full `DIV_CYCLES`, then HI/LO stay unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- **Reserved op:** `mdu_op`=7 without the feature: treated as idle; `start`=0.
- **Reads:** `rd_data` reflects registered HI/LO only; no bypass of an in-flight result. mfhi/mflo are stalled by the hazard unit while `start|busy`.

Optional Feature:
- Macro: `MDU_MADD_EN`.
- **Defined:** `mdu_op`=7 is madd.
  - {HI,LO} += signed(rs)*signed(rt), 64-bit wrap-around.
  - Accumulates onto the HI/LO values present at writeback.
  - Latency `MULT_CYCLES`; `start`/`busy` behave as for mult.
- **Undefined:** `mdu_op`=7 is idle, `start`=0, no state change.

Test Plan:
1. Reset then idle: `hi`=`lo`=0, `busy`=0, `rd_data`=0 for `rd_sel` 0 and 1.
2. mult rs=0xFFFFFFFE, rt=3 → `start`=1 in the issue cycle, `busy`=1 for exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
3. div rs=0xFFFFFFF9 (-7), rt=2 → `busy` for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. divu 7/0 → HI/LO unchanged after 10 cycles.
4. During busy, apply mtlo rs=0x1234 and a second mult → both ignored. Final HI/LO equal the first operation's result.
5. `kill`=1 with mult → `start`=0, `busy` stays 0, HI/LO unchanged. `kill`=1 with mthi → HI unchanged. Reset asserted at busy cycle 3 of a div → `busy`=0 next cycle, HI=LO=0.
6. (`MDU_MADD_EN`) mthi 0, mtlo 0xFFFFFFFF, then madd rs=1, rt=1 → after 5 cycles HI=1, LO=0. Without the macro, op 7 leaves HI=0, LO=0xFFFFFFFF and `busy`=0.

Source files
------------

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - MIPS E-stage multiply/divide unit holding HI/LO with fixed-latency mult/div.
// Optional madd on mdu_op=7 when MDU_MADD_EN is defined.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mdu_op,
    input  logic        kill,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_sel,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic        start_req;
    logic        is_mul_req;
    logic        mul_signed;
    logic [63:0] ext_a, ext_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    always_comb begin
        start_req  = 1'b0;
        is_mul_req = 1'b0;
        case (mdu_op)
            OP_MULT, OP_MULTU: begin
                start_req  = 1'b1;
                is_mul_req = 1'b1;
            end
            OP_DIV, OP_DIVU: start_req = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD: begin
                start_req  = 1'b1;
                is_mul_req = 1'b1;
            end
`endif
            default: start_req = 1'b0;
        endcase
        start = start_req & ~kill & ~busy_q;
    end

    // Result datapath works from the latched operands so forwarding changes after issue are harmless
    always_comb begin
        mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD);
        ext_a = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = ext_a * ext_b;

        a_neg = (op_q == OP_DIV) && a_q[31];
        b_neg = (op_q == OP_DIV) && b_q[31];
        a_mag = a_neg ? (32'd0 - a_q) : a_q;
        b_mag = b_neg ? (32'd0 - b_q) : b_q;
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        // Magnitude division makes 0x80000000 / -1 wrap to 0x80000000 with zero remainder
        quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem  = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                cnt_d  = 4'd0;
                case (op_q)
                    OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                    OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + prod;
                    OP_DIV, OP_DIVU: begin
                        if (b_q != 32'd0) begin
                            lo_d = quot;
                            hi_d = rem;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (start) begin
            a_d    = rs_val;
            b_d    = rt_val;
            op_d   = mdu_op;
            busy_d = 1'b1;
            cnt_d  = is_mul_req ? MULT_CNT : DIV_CNT;
        end else if (!kill) begin
            if (mdu_op == OP_MTHI) hi_d = rs_val;
            if (mdu_op == OP_MTLO) lo_d = rs_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
            op_q   <= 3'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed self-checking bench for mdu_unit.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mdu_op;
    logic        kill;
    logic [31:0] rs_val, rt_val;
    logic        rd_sel;
    logic        start, busy;
    logic [31:0] hi, lo, rd_data;

    int checks = 0;
    int failures = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .mdu_op(mdu_op), .kill(kill),
        .rs_val(rs_val), .rt_val(rt_val), .rd_sel(rd_sel),
        .start(start), .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, reports start seen before the edge and busy cycles until it drops
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic st, output int nbusy);
        mdu_op = op; rs_val = a; rt_val = b;
        #1;
        st = start;
        step();
        mdu_op = 3'd0;
        nbusy = 0;
        while (busy && nbusy < 40) begin
            nbusy++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mdu_op = 3'd0; kill = 1'b0; rs_val = '0; rt_val = '0; rd_sel = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rd_sel = 1'b0; #1;
        checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_hi got=%h exp=0", rd_data); end
        rd_sel = 1'b1; #1;
        checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_lo got=%h exp=0", rd_data); end
    endtask

    task automatic test_mult();
        logic st; int nb;
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, st, nb);
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL mult_start got=%b exp=1", st); end
        checks++; if (nb != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", nb); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
        run_op(3'd2, 32'hFFFFFFFE, 32'd3, st, nb);
        checks++; if (nb != 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", nb); end
        checks++; if (hi !== 32'h00000002) begin failures++; $display("FAIL multu_hi got=%h exp=00000002", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffa", lo); end
        rd_sel = 1'b0; #1;
        checks++; if (rd_data !== 32'h00000002) begin failures++; $display("FAIL rd_hi got=%h exp=00000002", rd_data); end
        rd_sel = 1'b1; #1;
        checks++; if (rd_data !== 32'hFFFFFFFA) begin failures++; $display("FAIL rd_lo got=%h exp=fffffffa", rd_data); end
    endtask

    task automatic test_div();
        logic st; int nb;
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, st, nb);
        checks++; if (nb != 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", nb); end
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, st, nb);
        checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
        run_op(3'd4, 32'd100, 32'd7, st, nb);
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("FAIL divu_qr got=%h/%h exp=0000000e/00000002", lo, hi); end
        run_op(3'd4, 32'd7, 32'd0, st, nb);
        checks++; if (nb != 10) begin failures++; $display("FAIL divz_busy_cycles got=%0d exp=10", nb); end
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("FAIL divz_unchanged got=%h/%h exp=0000000e/00000002", lo, hi); end
    endtask

    task automatic test_busy_ignore();
        logic st; int nb;
        mdu_op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
        step();
        mdu_op = 3'd6; rs_val = 32'h1234;
        step();
        mdu_op = 3'd1; rs_val = 32'd9; rt_val = 32'd9;
        #1;
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL busy_start got=%b exp=0", start); end
        step();
        mdu_op = 3'd0;
        nb = 0;
        while (busy && nb < 40) begin nb++; step(); end
        checks++; if (nb != 3) begin failures++; $display("FAIL busy_remaining got=%0d exp=3", nb); end
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin failures++; $display("FAIL busy_ignore got=%h/%h exp=00000000/00000006", hi, lo); end
        st = 1'b0;
    endtask

    task automatic test_kill_and_reset();
        logic st; int nb;
        kill = 1'b1;
        run_op(3'd1, 32'd5, 32'd5, st, nb);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL kill_start got=%b exp=0", st); end
        checks++; if (nb != 0) begin failures++; $display("FAIL kill_busy got=%0d exp=0", nb); end
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin failures++; $display("FAIL kill_mult got=%h/%h exp=00000000/00000006", hi, lo); end
        run_op(3'd5, 32'hDEADBEEF, 32'd0, st, nb);
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL kill_mthi got=%h exp=0", hi); end
        kill = 1'b0;
        run_op(3'd5, 32'hCAFE0001, 32'd0, st, nb);
        checks++; if (hi !== 32'hCAFE0001) begin failures++; $display("FAIL mthi got=%h exp=cafe0001", hi); end
        mdu_op = 3'd3; rs_val = 32'd100; rt_val = 32'd3;
        step();
        mdu_op = 3'd0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL reset_mid_hilo got=%h/%h exp=0/0", hi, lo); end
        step(); step(); step(); step(); step(); step(); step(); step();
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL reset_no_wb got=%h/%h exp=0/0", hi, lo); end
    endtask

    task automatic test_op7();
        logic st; int nb;
        run_op(3'd5, 32'd0, 32'd0, st, nb);
        run_op(3'd6, 32'hFFFFFFFF, 32'd0, st, nb);
        run_op(3'd7, 32'd1, 32'd1, st, nb);
`ifdef MDU_MADD_EN
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL madd_start got=%b exp=1", st); end
        checks++; if (nb != 5) begin failures++; $display("FAIL madd_busy got=%0d exp=5", nb); end
        checks++; if (hi !== 32'd1 || lo !== 32'd0) begin failures++; $display("FAIL madd_hilo got=%h/%h exp=00000001/00000000", hi, lo); end
`else
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL op7_start got=%b exp=0", st); end
        checks++; if (nb != 0) begin failures++; $display("FAIL op7_busy got=%0d exp=0", nb); end
        checks++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL op7_hilo got=%h/%h exp=00000000/ffffffff", hi, lo); end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_busy_ignore();
        test_kill_and_reset();
        test_op7();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
